// File: rtl/thread_fetch_sched.sv
// Fetch scheduler for the multithreaded front end: owns each thread's fetch PC,
// picks one eligible thread per cycle round-robin, parks threads on ITLB or
// I-cache misses, replays hazard-rejected fetches and applies branch redirects.
//
// Issue handshake: fetch_valid offers {fetch_thread, fetch_pc} whenever an
// eligible thread exists; the front end accepts it by holding fetch_stall low.
// A transfer happens exactly on a cycle with fetch_valid && !fetch_stall. While
// stalled, the offer is held unless eligibility itself changes. The offer never
// depends combinationally on fb_*/br_* inputs.
module thread_fetch_sched #(
    parameter int              N_THREADS = 4,
    parameter int              TID_W     = $clog2(N_THREADS),
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] BOOT_PC   = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_THREADS-1:0] thread_en,
    input  logic                 fetch_stall,
    output logic                 fetch_valid,
    output logic [TID_W-1:0]     fetch_thread,
    output logic [PC_W-1:0]      fetch_pc,
    input  logic                 fb_valid,
    input  logic [TID_W-1:0]     fb_thread,
    input  logic [PC_W-1:0]      fb_pc,
    input  logic                 fb_itlb_miss,
    input  logic                 fb_icache_miss,
    input  logic                 fb_hazard,
    input  logic                 tlb_fill_done,
    input  logic [TID_W-1:0]     tlb_fill_thread,
    input  logic                 ic_fill_done,
    input  logic [TID_W-1:0]     ic_fill_thread,
    input  logic                 br_valid,
    input  logic [TID_W-1:0]     br_thread,
    input  logic [PC_W-1:0]      br_target,
    output logic [N_THREADS-1:0] thread_waiting
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_TLB = 2'd1,
        ST_WAIT_MEM = 2'd2
    } thr_state_e;

    thr_state_e           state_q    [N_THREADS];
    thr_state_e           state_d    [N_THREADS];
    logic [PC_W-1:0]      pc_q       [N_THREADS];
    logic [PC_W-1:0]      pc_d       [N_THREADS];
    logic [N_THREADS-1:0] inflight_q;
    logic [N_THREADS-1:0] inflight_d;
    logic [TID_W-1:0]     rr_q;
    logic [TID_W-1:0]     rr_d;

    logic [N_THREADS-1:0] eligible;
    logic                 sel_found;
    logic [TID_W-1:0]     sel_tid;
    logic [TID_W-1:0]     scan_idx;
    logic                 issue;

    // Eligibility and round-robin pick, purely from registered state and enables.
    always_comb begin
        sel_found = 1'b0;
        sel_tid   = rr_q;
        scan_idx  = rr_q;
        for (int t = 0; t < N_THREADS; t++) begin
            eligible[t] = thread_en[t] && (state_q[t] == ST_RUN) && !inflight_q[t];
        end
        // Index arithmetic is TID_W wide, so the scan wraps naturally.
        for (int i = 0; i < N_THREADS; i++) begin
            scan_idx = rr_q + TID_W'(i);
            if (!sel_found && eligible[scan_idx]) begin
                sel_found = 1'b1;
                sel_tid   = scan_idx;
            end
        end
        issue = sel_found && !fetch_stall;
    end

    // State register: per-thread FSM, PCs, in-flight bits and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                state_q[t] <= ST_RUN;
                pc_q[t]    <= BOOT_PC;
            end
            inflight_q <= '0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            rr_q       <= rr_d;
        end
    end

    // Next state: issue, then fill wake-ups, then feedback, then redirect, so later
    // events override earlier ones on the same thread.
    always_comb begin
        rr_d       = issue ? (sel_tid + TID_W'(1)) : rr_q;
        inflight_d = inflight_q;
        for (int t = 0; t < N_THREADS; t++) begin
            state_d[t] = state_q[t];
            pc_d[t]    = pc_q[t];

            // Issue and feedback never hit the same thread: issue needs !inflight,
            // accepted feedback needs inflight.
            if (issue && (sel_tid == TID_W'(t))) begin
                pc_d[t]       = pc_q[t] + PC_W'(4);
                inflight_d[t] = 1'b1;
            end

            // Fills only wake a thread parked on the matching miss.
            if (tlb_fill_done && (tlb_fill_thread == TID_W'(t)) &&
                (state_q[t] == ST_WAIT_TLB)) begin
                state_d[t] = ST_RUN;
            end
            if (ic_fill_done && (ic_fill_thread == TID_W'(t)) &&
                (state_q[t] == ST_WAIT_MEM)) begin
                state_d[t] = ST_RUN;
            end

            // Feedback for a thread with nothing in flight is stale and dropped.
            if (fb_valid && (fb_thread == TID_W'(t)) && inflight_q[t]) begin
                inflight_d[t] = 1'b0;
                if (fb_itlb_miss) begin
                    pc_d[t]    = fb_pc;
                    state_d[t] = ST_WAIT_TLB;
                end else if (fb_icache_miss) begin
                    pc_d[t]    = fb_pc;
                    state_d[t] = ST_WAIT_MEM;
                end else if (fb_hazard) begin
                    pc_d[t]    = fb_pc;
                end
            end

            // A redirect wins over everything above but leaves inflight alone.
            if (br_valid && (br_thread == TID_W'(t))) begin
                pc_d[t]    = br_target;
                state_d[t] = ST_RUN;
            end
        end
    end

    // Outputs: the offered fetch and the per-thread parked flags.
    always_comb begin
        fetch_valid  = sel_found;
        fetch_thread = sel_tid;
        fetch_pc     = pc_q[sel_tid];
        for (int t = 0; t < N_THREADS; t++) begin
            thread_waiting[t] = (state_q[t] != ST_RUN);
        end
    end

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Bench for thread_fetch_sched: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a reference model.
module tb_thread_fetch_sched;

    localparam int          N    = 4;
    localparam logic [31:0] BOOT = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  thread_en;
    logic        fetch_stall;
    logic        fetch_valid;
    logic [1:0]  fetch_thread;
    logic [31:0] fetch_pc;
    logic        fb_valid;
    logic [1:0]  fb_thread;
    logic [31:0] fb_pc;
    logic        fb_itlb_miss;
    logic        fb_icache_miss;
    logic        fb_hazard;
    logic        tlb_fill_done;
    logic [1:0]  tlb_fill_thread;
    logic        ic_fill_done;
    logic [1:0]  ic_fill_thread;
    logic        br_valid;
    logic [1:0]  br_thread;
    logic [31:0] br_target;
    logic [3:0]  thread_waiting;

    thread_fetch_sched dut (
        .clk             (clk),
        .rst             (rst),
        .thread_en       (thread_en),
        .fetch_stall     (fetch_stall),
        .fetch_valid     (fetch_valid),
        .fetch_thread    (fetch_thread),
        .fetch_pc        (fetch_pc),
        .fb_valid        (fb_valid),
        .fb_thread       (fb_thread),
        .fb_pc           (fb_pc),
        .fb_itlb_miss    (fb_itlb_miss),
        .fb_icache_miss  (fb_icache_miss),
        .fb_hazard       (fb_hazard),
        .tlb_fill_done   (tlb_fill_done),
        .tlb_fill_thread (tlb_fill_thread),
        .ic_fill_done    (ic_fill_done),
        .ic_fill_thread  (ic_fill_thread),
        .br_valid        (br_valid),
        .br_thread       (br_thread),
        .br_target       (br_target),
        .thread_waiting  (thread_waiting)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard queue for the randomized run: {waiting, valid, thread, pc}
    logic [38:0] exp_q[$];

    // Reference model state: thread status 0=running, 1=parked on ITLB, 2=parked on I-cache
    logic [31:0] m_pc  [N];
    int          m_st  [N];
    bit          m_inf [N];
    int          m_rr;

    typedef struct {
        bit          rst_before;
        logic [3:0]  en;
        logic        fb_v;
        logic [1:0]  fb_t;
        logic        exp_v;
        logic [1:0]  exp_t;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [1:0] t,
                             input logic [31:0] pc, input logic [3:0] w);
        check({name, "_valid"}, 64'(fetch_valid), 64'(v));
        if (v) begin
            check({name, "_thread"}, 64'(fetch_thread), 64'(t));
            check({name, "_pc"}, 64'(fetch_pc), 64'(pc));
        end
        check({name, "_waiting"}, 64'(thread_waiting), 64'(w));
    endtask

    // Driver tasks: one clock, then drop all single-cycle pulses
    task automatic tick();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        fb_valid       = 1'b0;
        fb_itlb_miss   = 1'b0;
        fb_icache_miss = 1'b0;
        fb_hazard      = 1'b0;
        tlb_fill_done  = 1'b0;
        ic_fill_done   = 1'b0;
        br_valid       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    task automatic drive_fb(input logic [1:0] t, input logic [31:0] pc,
                            input logic itlb, input logic ic, input logic hz);
        fb_valid       = 1'b1;
        fb_thread      = t;
        fb_pc          = pc;
        fb_itlb_miss   = itlb;
        fb_icache_miss = ic;
        fb_hazard      = hz;
    endtask

    task automatic m_reset();
        for (int t = 0; t < N; t++) begin
            m_pc[t]  = BOOT;
            m_st[t]  = 0;
            m_inf[t] = 1'b0;
        end
        m_rr = 0;
    endtask

    task automatic m_pick(output bit v, output int s);
        v = 1'b0;
        s = 0;
        for (int i = 0; i < N; i++) begin
            int t;
            t = (m_rr + i) % N;
            if (!v && thread_en[t] && m_st[t] == 0 && !m_inf[t]) begin
                v = 1'b1;
                s = t;
            end
        end
    endtask

    // Apply one cycle of the rules to the model using the currently driven inputs
    task automatic m_step(input bit v, input int s);
        if (v && !fetch_stall) begin
            m_pc[s]  = m_pc[s] + 32'd4;
            m_inf[s] = 1'b1;
            m_rr     = (s + 1) % N;
        end else if (fb_valid && m_inf[fb_thread]) begin
            // handled below; keeps the issued thread's fresh inflight intact
        end
        if (tlb_fill_done && m_st[tlb_fill_thread] == 1) m_st[tlb_fill_thread] = 0;
        if (ic_fill_done && m_st[ic_fill_thread] == 2) m_st[ic_fill_thread] = 0;
        if (fb_valid && m_inf[fb_thread] && !(v && !fetch_stall && s == int'(fb_thread))) begin
            m_inf[fb_thread] = 1'b0;
            if (fb_itlb_miss) begin
                m_pc[fb_thread] = fb_pc;
                m_st[fb_thread] = 1;
            end else if (fb_icache_miss) begin
                m_pc[fb_thread] = fb_pc;
                m_st[fb_thread] = 2;
            end else if (fb_hazard) begin
                m_pc[fb_thread] = fb_pc;
            end
        end
        if (br_valid) begin
            m_pc[br_thread] = br_target;
            m_st[br_thread] = 0;
        end
    endtask

    initial begin
        bit          mv;
        int          ms;
        bit          last_iss;
        logic [1:0]  last_t;
        logic [31:0] last_pc;
        logic [3:0]  mw;
        logic [38:0] e;

        rst = 1'b0; thread_en = 4'hF; fetch_stall = 1'b0;
        fb_valid = 1'b0; fb_thread = '0; fb_pc = '0;
        fb_itlb_miss = 1'b0; fb_icache_miss = 1'b0; fb_hazard = 1'b0;
        tlb_fill_done = 1'b0; tlb_fill_thread = '0;
        ic_fill_done = 1'b0; ic_fill_thread = '0;
        br_valid = 1'b0; br_thread = '0; br_target = '0;

        // Vector table: round-robin over four threads, then a lone thread
        for (int k = 0; k < 8; k++) begin
            vecs[k].rst_before = (k == 0);
            vecs[k].en         = 4'hF;
            vecs[k].fb_v       = (k > 0);
            vecs[k].fb_t       = 2'((k + 3) % 4);
            vecs[k].exp_v      = 1'b1;
            vecs[k].exp_t      = 2'(k % 4);
            vecs[k].exp_pc     = BOOT + 32'(4 * (k / 4));
        end
        for (int k = 0; k < 5; k++) begin
            vecs[8 + k].rst_before = (k == 0);
            vecs[8 + k].en         = 4'b0001;
            vecs[8 + k].fb_v       = (k % 2 == 1);
            vecs[8 + k].fb_t       = 2'd0;
            vecs[8 + k].exp_v      = (k % 2 == 0);
            vecs[8 + k].exp_t      = 2'd0;
            vecs[8 + k].exp_pc     = BOOT + 32'(4 * (k / 2));
        end

        for (int i = 0; i < 13; i++) begin
            thread_en = vecs[i].en;
            if (vecs[i].rst_before) do_reset();
            if (vecs[i].fb_v) drive_fb(vecs[i].fb_t, 32'h0, 1'b0, 1'b0, 1'b0);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_t, vecs[i].exp_pc, 4'b0000);
            tick();
        end

        // I-cache miss parks T1 until its fill, then it refetches the missed PC
        thread_en = 4'b0010; fetch_stall = 1'b0; do_reset();
        #1 check_out("icm_c0", 1'b1, 2'd1, BOOT, 4'b0000); tick();
        drive_fb(2'd1, BOOT, 1'b0, 1'b0, 1'b0);
        #1 check_out("icm_c1", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        #1 check_out("icm_c2", 1'b1, 2'd1, 32'h1004, 4'b0000); tick();
        drive_fb(2'd1, 32'h1004, 1'b0, 1'b1, 1'b0);
        #1 check_out("icm_c3", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        #1 check_out("icm_c4", 1'b0, 2'd0, 32'h0, 4'b0010); tick();
        ic_fill_done = 1'b1; ic_fill_thread = 2'd1;
        #1 check_out("icm_c5", 1'b0, 2'd0, 32'h0, 4'b0010); tick();
        #1 check_out("icm_c6", 1'b1, 2'd1, 32'h1004, 4'b0000); tick();

        // ITLB miss wins over a simultaneous I-cache miss; wrong fill ignored
        thread_en = 4'b0100; do_reset();
        #1 check_out("tlb_c0", 1'b1, 2'd2, BOOT, 4'b0000); tick();
        drive_fb(2'd2, BOOT, 1'b1, 1'b1, 1'b0);
        #1 check_out("tlb_c1", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        ic_fill_done = 1'b1; ic_fill_thread = 2'd2;
        #1 check_out("tlb_c2", 1'b0, 2'd0, 32'h0, 4'b0100); tick();
        tlb_fill_done = 1'b1; tlb_fill_thread = 2'd2;
        #1 check_out("tlb_c3", 1'b0, 2'd0, 32'h0, 4'b0100); tick();
        #1 check_out("tlb_c4", 1'b1, 2'd2, BOOT, 4'b0000); tick();

        // Redirect beats hazard feedback, and a redirect resumes a parked thread
        thread_en = 4'b0001; do_reset();
        #1 check_out("br_c0", 1'b1, 2'd0, BOOT, 4'b0000); tick();
        drive_fb(2'd0, BOOT, 1'b0, 1'b0, 1'b0);
        #1 check_out("br_c1", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        #1 check_out("br_c2", 1'b1, 2'd0, 32'h1004, 4'b0000); tick();
        drive_fb(2'd0, 32'h1004, 1'b0, 1'b0, 1'b0);
        #1 check_out("br_c3", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        #1 check_out("br_c4", 1'b1, 2'd0, 32'h1008, 4'b0000); tick();
        drive_fb(2'd0, 32'h1008, 1'b0, 1'b0, 1'b1);
        br_valid = 1'b1; br_thread = 2'd0; br_target = 32'h2000;
        #1 check_out("br_c5", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        #1 check_out("br_c6", 1'b1, 2'd0, 32'h2000, 4'b0000); tick();
        drive_fb(2'd0, 32'h2000, 1'b0, 1'b1, 1'b0);
        #1 check_out("br_c7", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        br_valid = 1'b1; br_thread = 2'd0; br_target = 32'h2000;
        #1 check_out("br_c8", 1'b0, 2'd0, 32'h0, 4'b0001); tick();
        #1 check_out("br_c9", 1'b1, 2'd0, 32'h2000, 4'b0000); tick();

        // Reset while T3 is parked and T0 is in flight; stale fill/feedback ignored
        thread_en = 4'b1001; do_reset();
        #1 check_out("rst_c0", 1'b1, 2'd0, BOOT, 4'b0000); tick();
        drive_fb(2'd0, BOOT, 1'b0, 1'b0, 1'b0);
        #1 check_out("rst_c1", 1'b1, 2'd3, BOOT, 4'b0000); tick();
        drive_fb(2'd3, BOOT, 1'b0, 1'b1, 1'b0);
        #1 check_out("rst_c2", 1'b1, 2'd0, 32'h1004, 4'b0000); tick();
        #1 check_out("rst_c3", 1'b0, 2'd0, 32'h0, 4'b1000);
        rst = 1'b1; tick();
        fetch_stall = 1'b1;
        ic_fill_done = 1'b1; ic_fill_thread = 2'd3;
        drive_fb(2'd3, 32'h5554, 1'b1, 1'b0, 1'b0);
        #1 check_out("rst_c4", 1'b1, 2'd0, BOOT, 4'b0000); tick();
        fetch_stall = 1'b0;
        #1 check_out("rst_c5", 1'b1, 2'd0, BOOT, 4'b0000); tick();
        #1 check_out("rst_c6", 1'b1, 2'd3, BOOT, 4'b0000); tick();

        // Redirect beats the issue increment, and the PC wraps past 2^32
        thread_en = 4'b0001; do_reset();
        br_valid = 1'b1; br_thread = 2'd0; br_target = 32'hFFFF_FFFC;
        #1 check_out("wrap_c0", 1'b1, 2'd0, BOOT, 4'b0000); tick();
        drive_fb(2'd0, BOOT, 1'b0, 1'b0, 1'b0);
        #1 check_out("wrap_c1", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        #1 check_out("wrap_c2", 1'b1, 2'd0, 32'hFFFF_FFFC, 4'b0000); tick();
        drive_fb(2'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        #1 check_out("wrap_c3", 1'b0, 2'd0, 32'h0, 4'b0000); tick();
        #1 check_out("wrap_c4", 1'b1, 2'd0, 32'h0, 4'b0000); tick();

        // Randomized run against the reference model
        thread_en = 4'hF; fetch_stall = 1'b0; do_reset(); m_reset();
        last_iss = 1'b0; last_t = '0; last_pc = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) thread_en = 4'($urandom_range(0, 15));
            fetch_stall = ($urandom_range(0, 3) == 0);
            if (last_iss) begin
                drive_fb(last_t, last_pc, ($urandom_range(0, 9) == 0),
                         ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end else if ($urandom_range(0, 19) == 0) begin
                drive_fb(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            tlb_fill_done   = ($urandom_range(0, 4) == 0);
            tlb_fill_thread = 2'($urandom_range(0, 3));
            ic_fill_done    = ($urandom_range(0, 4) == 0);
            ic_fill_thread  = 2'($urandom_range(0, 3));
            br_valid        = ($urandom_range(0, 24) == 0);
            br_thread       = 2'($urandom_range(0, 3));
            br_target       = $urandom & 32'hFFFF_FFFC;
            rst             = ($urandom_range(0, 299) == 0);
            #1;
            m_pick(mv, ms);
            for (int t = 0; t < N; t++) mw[t] = (m_st[t] != 0);
            exp_q.push_back({mw, mv, 2'(ms), m_pc[ms]});
            e = exp_q.pop_front();
            check_out($sformatf("rnd%0d", c), e[34], e[33:32], e[31:0], e[38:35]);
            if (rst) begin
                m_reset();
                last_iss = 1'b0;
            end else begin
                last_iss = mv && !fetch_stall;
                last_t   = 2'(ms);
                last_pc  = m_pc[ms];
                m_step(mv, ms);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/thread_fetch_sched.md
Name: thread_fetch_sched

Overview:
- Per-cycle fetch scheduler for the multithreaded front end. Picks which hardware thread issues its PC to the ITLB/I-cache, and owns each thread's fetch PC.
- Parks threads on ITLB or I-cache misses and wakes them on fill completion.
- Rewinds threads whose fetched instruction the hazard unit rejected.
- Applies branch redirects from execute.

Parameters:
- N_THREADS, 4, number of hardware threads (power of two, ≥2).
- TID_W, $clog2(N_THREADS), thread id width.
- PC_W, 32, PC width.
- BOOT_PC, 32'h0000_1000, reset PC for every thread.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- thread_en  in  N_THREADS  per-thread enable; disabled threads are never issued.
- fetch_stall  in  1  front end cannot accept an issue this cycle.
- fetch_valid  out  1  an eligible thread exists.
- fetch_thread  out  TID_W  selected thread.
- fetch_pc  out  PC_W  selected thread's PC.
- fb_valid  in  1  feedback for the instruction issued last cycle.
- fb_thread  in  TID_W  thread of the feedback.
- fb_pc  in  PC_W  PC of the fed-back instruction.
- fb_itlb_miss  in  1  ITLB missed.
- fb_icache_miss  in  1  I-cache missed.
- fb_hazard  in  1  hazard unit rejected the instruction (isvalid=0).
- tlb_fill_done  in  1  ITLB fill complete.
- tlb_fill_thread  in  TID_W  thread the ITLB fill was for.
- ic_fill_done  in  1  I-cache fill complete.
- ic_fill_thread  in  TID_W  thread the I-cache fill was for.
- br_valid  in  1  taken-branch redirect.
- br_thread  in  TID_W  redirected thread.
- br_target  in  PC_W  redirect target.
- thread_waiting  out  N_THREADS  bit t set when thread t is in WAIT_TLB or WAIT_MEM.

Behaviour:
- Per-thread state: pc[PC_W], inflight bit, FSM state ∈ {RUN, WAIT_TLB, WAIT_MEM}.
- Reset (on clk edge with rst=1):
  - all pc=BOOT_PC, state=RUN, inflight=0.
  - RR pointer set so thread 0 has top priority.
  - Outputs after reset: fetch_valid=1 only if thread_en≠0; thread_waiting=0.
  - Reset mid-wait or mid-flight discards everything; stale fills and feedback arriving after reset are ignored (inflight=0, state=RUN).
- Eligible(t) = thread_en[t] && state==RUN && !inflight.
- Selection (combinational from registered state):
  - fetch_valid = any eligible.
  - fetch_thread = first eligible at or after rr_ptr, wrapping from N_THREADS-1 to 0.
  - fetch_pc = pc[fetch_thread].
  - Outputs do not depend on fb_*/br_* in the same cycle.
- Issue happens when fetch_valid && !fetch_stall. At the edge: pc[sel] += 4 (modulo 2^PC_W wrap), inflight[sel]=1, rr_ptr=sel+1 mod N_THREADS.
- With fetch_stall=1: no state change from issue; selection is held unless eligibility changes.
- Feedback latency is exactly 1 cycle: an issue at cycle n gets fb_valid with fb_thread=sel at n+1. On fb_valid, inflight[fb_thread] clears. Resulting action, in priority order:
  - fb_itlb_miss: pc=fb_pc, state=WAIT_TLB.
  - else fb_icache_miss: pc=fb_pc, state=WAIT_MEM.
  - else fb_hazard: pc=fb_pc, state stays RUN (replay).
  - else no change.
- A thread therefore has at most one instruction in flight. A lone running thread issues every other cycle; a thread that has just received feedback is eligible the following cycle.
- Wake-up:
  - tlb_fill_done with state[tlb_fill_thread]==WAIT_TLB → RUN.
  - ic_fill_done with state[ic_fill_thread]==WAIT_MEM → RUN.
  - A fill for a thread in any other state is ignored.
  - Both fills in one cycle for different threads are both applied.
- Redirect br_valid for thread b: pc[b]=br_target, state[b]=RUN (cancels any wait); inflight[b] is untouched.
- Same-cycle conflicts on one thread:
  - br beats fb: pc=br_target, state=RUN, miss/hazard discarded, inflight still clears.
  - br beats the issue increment.
  - fill plus fb on the same thread: fb wins.
- Issue and fb for different threads in the same cycle: both applied.
- A fb_valid whose thread has inflight=0 is ignored entirely.
- thread_waiting is a registered copy of the state encoding, so it is valid from the cycle after the transition.

Test Plan:
1. Reset, thread_en=4'b1111, fetch_stall=0, no misses → issue order T0,T1,T2,T3,T0… with T0 PCs 0x1000,0x1004,…
2. thread_en=4'b0001, fb clean each cycle → fetch_valid alternates 1,0,1,0; PCs 0x1000,0x1004,0x1008.
3. T1 issues 0x1004, fb_icache_miss at n+1 → thread_waiting[1]=1 from n+2; T1 skipped until ic_fill_done(T1); T1 next fetches 0x1004.
4. T2 gets fb_itlb_miss and fb_icache_miss together → WAIT_TLB; ic_fill_done(T2) has no effect; tlb_fill_done(T2) → RUN, refetch fb_pc.
5. br_valid(T0, 0x2000) in the same cycle as fb_hazard(T0, 0x1008) → T0 next fetches 0x2000; with T0 in WAIT_MEM, the redirect resumes it at 0x2000.
6. rst asserted while T3 is in WAIT_MEM with fb pending → all threads RUN at 0x1000; a following ic_fill_done(T3) and fb_valid(T3) change nothing.
